mem_bus_sched: RTL and testbench
================================

# mem_bus_sched

Two-requester scheduler and serializer for the C2 memory bus. Accepts whole-cache-line read/write requests from two cache-side requesters (0 = instruction, 1 = data), arbitrates round-robin, and converts each request into a C2 command plus a beat-serialized burst of BUS_SIZE-bit words. Sits between the L1 caches and the memory model; exactly one C2 transaction is outstanding at any time.

## Interface
- MEM_ADDR_SIZE, 19: byte-address width.
- CACHE_OFFSET_SIZE, 4: line-offset bits; line address width A = MEM_ADDR_SIZE-CACHE_OFFSET_SIZE.
- BUS_SIZE, 16: C2 data bus width.
- CACHE_LINE_SIZE, 16: line size in bytes; L = CACHE_LINE_SIZE*8; BEATS = L/BUS_SIZE (8).
- TIMEOUT, 256: watchdog limit in cycles (used only with the macro).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request.
- req_write  in  2  per-requester 1 = write line, 0 = read line.
- req_addr  in  2*A  line addresses; requester i at [i*A +: A].
- req_wdata  in  2*L  write lines; requester i at [i*L +: L].
- req_ready  out  2  one-hot accept strobe.
- resp_valid  out  2  one-hot completion strobe.
- resp_rdata  out  L  read line, qualified by resp_valid.
- resp_err  out  1  timeout flag, qualified by resp_valid.
- c2_addr  out  A  line address to memory.
- c2_cmd  out  2  0 NOP, 2 READ, 3 WRITE.
- c2_wdata  out  BUS_SIZE  write beat.
- c2_cmd_in  in  2  memory reply; 1 = RESPONSE, all other values ignored.
- c2_rdata  in  BUS_SIZE  read beat, valid when c2_cmd_in == 1.

## Operation
- States: IDLE, RD_CMD, RD_WAIT, WR_BURST, WR_WAIT, DONE.
- IDLE: if any req_valid, pick grant g (round-robin); req_ready[g]=1 combinationally that cycle; at the edge latch addr, wdata, write, g; clear line buffer and beat counter; go to RD_CMD or WR_BURST.
- Round-robin: after reset requester 0 wins a tie; after each grant the other requester has priority. A lone requester is granted regardless of pointer.
- RD_CMD (1 cycle): c2_cmd=READ, c2_addr=latched addr → RD_WAIT.
- RD_WAIT: c2_cmd=NOP; each cycle with c2_cmd_in==RESPONSE stores c2_rdata into beat k (bits [k*BUS_SIZE +: BUS_SIZE], k from 0, low beat first), k++. Gaps between beats allowed. After beat BEATS-1 → DONE.
- WR_BURST (BEATS consecutive cycles): c2_cmd=WRITE, c2_addr constant, c2_wdata = beat k of the latched line, low first → WR_WAIT.
- WR_WAIT: c2_cmd=NOP; first RESPONSE → DONE.
- DONE (1 cycle): resp_valid[g]=1, resp_rdata = line buffer (reads), 0 (writes), resp_err=0 → IDLE.
- RESPONSE outside RD_WAIT/WR_WAIT is ignored.
- Outside RD_CMD/WR_BURST: c2_cmd=0, c2_addr=0, c2_wdata=0.
- Requesters hold req_valid/addr/wdata until req_ready. After acceptance they may change freely.

## Timing
- Reset (reset==0 at an edge): state IDLE, all outputs 0, RR pointer favours requester 0, buffer cleared. Mid-transaction reset aborts with no resp_valid.
- Accept edge = cycle 0. Read: READ on cycle 1. If memory sends beats on cycles 1+d .. 1+d+BEATS-1, resp_valid is on cycle 2+d+BEATS-1.
- Write: WRITE on cycles 1..BEATS. If RESPONSE is on cycle c, resp_valid is on cycle c+1.
- Earliest next req_ready is the cycle after DONE. Back-to-back throughput is one transaction per (service time + 2) cycles.

## Configuration
- MEM_BUS_SCHED_TIMEOUT_EN defined: a counter runs in RD_WAIT/WR_WAIT. It clears on entry and on every RESPONSE. On reaching TIMEOUT → DONE with resp_err=1 and resp_rdata=0.
- Undefined: no counter; wait states persist indefinitely; resp_err tied 0.

## Test plan
- Read req0 addr 0x00A5; memory replies d=3, beats 0x1111..0x8888 → READ on cycle 1, resp_valid=2'b01 on cycle 12, resp_rdata=0x8888_7777_…_1111, resp_err=0.
- Write req1 addr 0x7FFF, wdata 0x0123456789ABCDEF_FEDCBA9876543210 → 8 WRITE cycles, c2_addr 0x7FFF, beats 0x3210, 0x7654, …, 0x0123; RESPONSE 5 cycles later → resp_valid=2'b10 next cycle.
- req_valid=2'b11 held after reset, memory always responds → grants 0,1,0,1; each req_ready is one-hot and one cycle.
- Read with beats gapped (RESPONSE on alternating cycles) → line assembled correctly; stray RESPONSE during RD_CMD is ignored.
- Macro on, TIMEOUT=16, no reply → resp_err=1 with resp_rdata=0, 16 cycles after entering RD_WAIT. Macro off → stays in RD_WAIT for 1000 cycles.
- Reset low in RD_WAIT after 3 beats → all outputs 0 next cycle, no resp_valid; a following read completes normally.

Source files
------------

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: two-requester round-robin scheduler and beat serializer for
// the C2 memory bus. Requester 0 is the instruction cache, requester 1 the
// data cache. Exactly one C2 transaction is in flight at any time.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-low reset
//   req_valid/write   per-requester request and direction (1 = write line)
//   req_addr/wdata    packed per-requester line address / write line
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   resp_valid        one-hot completion strobe
//   resp_rdata/err    read line / timeout flag, qualified by resp_valid
//   c2_addr/cmd/wdata command, line address and write beat to memory
//   c2_cmd_in/rdata   memory reply (1 = RESPONSE) and read beat
//
// Build option: define MEM_BUS_SCHED_TIMEOUT_EN to enable the wait-state
// watchdog (TIMEOUT cycles without a RESPONSE ends the transaction with
// resp_err = 1). Without it resp_err is tied low.
module mem_bus_sched #(
   parameter int MEM_ADDR_SIZE     = 19,
   parameter int CACHE_OFFSET_SIZE = 4,
   parameter int BUS_SIZE          = 16,
   parameter int CACHE_LINE_SIZE   = 16,
   parameter int TIMEOUT           = 256
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [1:0]                                         req_valid,
   input  logic [1:0]                                         req_write,
   input  logic [2*(MEM_ADDR_SIZE-CACHE_OFFSET_SIZE)-1:0]     req_addr,
   input  logic [2*CACHE_LINE_SIZE*8-1:0]                     req_wdata,
   output logic [1:0]                                         req_ready,
   output logic [1:0]                                         resp_valid,
   output logic [CACHE_LINE_SIZE*8-1:0]                       resp_rdata,
   output logic                                               resp_err,
   output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0]         c2_addr,
   output logic [1:0]                                         c2_cmd,
   output logic [BUS_SIZE-1:0]                                c2_wdata,
   input  logic [1:0]                                         c2_cmd_in,
   input  logic [BUS_SIZE-1:0]                                c2_rdata
);

   localparam int A     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
   localparam int L     = CACHE_LINE_SIZE * 8;
   localparam int BEATS = L / BUS_SIZE;
   localparam int BW    = $clog2(BEATS);

   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_RESP  = 2'd1;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("mem_bus_sched: TIMEOUT must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_BURST,
      WR_WAIT,
      DONE
   } state_t;

   state_t            state_q;
   logic              grant_q;   // requester being served
   logic              rr_q;      // requester that wins a tie
   logic [A-1:0]      addr_q;
   logic [L-1:0]      wdata_q;
   logic [L-1:0]      line_q;
   logic [BW-1:0]     beat_q;

   logic [1:0]          c2_cmd_q;
   logic [A-1:0]        c2_addr_q;
   logic [BUS_SIZE-1:0] c2_wdata_q;
   logic [1:0]          resp_valid_q;
   logic [L-1:0]        resp_rdata_q;

`ifdef MEM_BUS_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] timer_q;
   logic          resp_err_q;
`endif

   logic                gnt;
   logic [A-1:0]        sel_addr;
   logic [L-1:0]        sel_wdata;
   logic                beat_in;
   logic                last_beat;
   logic [BW-1:0]       beat_nxt;
   logic [L-1:0]        line_merged;
   logic [BUS_SIZE-1:0] wbeat_nxt;
   logic [1:0]          grant_oh;

   always_comb begin
      // A lone requester wins outright; a tie goes to rr_q.
      gnt       = (req_valid == 2'b11) ? rr_q : req_valid[1];
      sel_addr  = gnt ? req_addr[2*A-1:A]   : req_addr[A-1:0];
      sel_wdata = gnt ? req_wdata[2*L-1:L]  : req_wdata[L-1:0];
      req_ready = '0;
      if (state_q == IDLE && req_valid != 2'b00) begin
         req_ready = gnt ? 2'b10 : 2'b01;
      end
      grant_oh  = grant_q ? 2'b10 : 2'b01;
      beat_in   = (c2_cmd_in == CMD_RESP);
      last_beat = (beat_q == BW'(BEATS - 1));
      beat_nxt  = beat_q + 1'b1;
      line_merged = line_q;
      line_merged[beat_q*BUS_SIZE +: BUS_SIZE] = c2_rdata;
      wbeat_nxt = wdata_q[beat_nxt*BUS_SIZE +: BUS_SIZE];
   end

   // Outputs are registered: each branch loads the value the next state
   // presents, everything else falls back to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         rr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         line_q       <= '0;
         beat_q       <= '0;
         c2_cmd_q     <= CMD_NOP;
         c2_addr_q    <= '0;
         c2_wdata_q   <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
         timer_q      <= '0;
         resp_err_q   <= 1'b0;
`endif
      end else begin
         c2_cmd_q     <= CMD_NOP;
         c2_addr_q    <= '0;
         c2_wdata_q   <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
         resp_err_q   <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  grant_q   <= gnt;
                  rr_q      <= ~gnt;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  line_q    <= '0;
                  beat_q    <= '0;
                  c2_addr_q <= sel_addr;
                  if (req_write[gnt]) begin
                     state_q    <= WR_BURST;
                     c2_cmd_q   <= CMD_WRITE;
                     c2_wdata_q <= sel_wdata[BUS_SIZE-1:0];
                  end else begin
                     state_q  <= RD_CMD;
                     c2_cmd_q <= CMD_READ;
                  end
               end
            end

            RD_CMD: begin
               state_q <= RD_WAIT;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
               timer_q <= '0;
`endif
            end

            RD_WAIT: begin
               if (beat_in) begin
                  line_q <= line_merged;
                  beat_q <= beat_nxt;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
                  timer_q <= '0;
`endif
                  if (last_beat) begin
                     state_q      <= DONE;
                     resp_valid_q <= grant_oh;
                     resp_rdata_q <= line_merged;
                  end
               end
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
               else if (timer_q == TW'(TIMEOUT - 1)) begin
                  state_q      <= DONE;
                  resp_valid_q <= grant_oh;
                  resp_err_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
`endif
            end

            WR_BURST: begin
               // beat_q indexes the beat on the bus this cycle.
               if (last_beat) begin
                  state_q <= WR_WAIT;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
                  timer_q <= '0;
`endif
               end else begin
                  beat_q     <= beat_nxt;
                  c2_cmd_q   <= CMD_WRITE;
                  c2_addr_q  <= addr_q;
                  c2_wdata_q <= wbeat_nxt;
               end
            end

            WR_WAIT: begin
               if (beat_in) begin
                  state_q      <= DONE;
                  resp_valid_q <= grant_oh;
               end
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
               else if (timer_q == TW'(TIMEOUT - 1)) begin
                  state_q      <= DONE;
                  resp_valid_q <= grant_oh;
                  resp_err_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
`endif
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign c2_cmd     = c2_cmd_q;
   assign c2_addr    = c2_addr_q;
   assign c2_wdata   = c2_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
   assign resp_err   = resp_err_q;
`else
   assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: scoreboard bench for mem_bus_sched. Stimulus pushes the
// expected grants, C2 command beats and responses (each tagged with the
// cycle it must appear in); a negedge monitor pops and compares them.
module tb_mem_bus_sched;

   localparam int A   = 15;
   localparam int L   = 128;
   localparam int BUS = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     req_valid, req_write;
   logic [2*A-1:0] req_addr;
   logic [2*L-1:0] req_wdata;
   logic [1:0]     req_ready, resp_valid;
   logic [L-1:0]   resp_rdata;
   logic           resp_err;
   logic [A-1:0]   c2_addr;
   logic [1:0]     c2_cmd;
   logic [BUS-1:0] c2_wdata;
   logic [1:0]     c2_cmd_in;
   logic [BUS-1:0] c2_rdata;

   always #5 clk = ~clk;

   mem_bus_sched #(
      .MEM_ADDR_SIZE(19), .CACHE_OFFSET_SIZE(4), .BUS_SIZE(16),
      .CACHE_LINE_SIZE(16), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .c2_addr(c2_addr), .c2_cmd(c2_cmd), .c2_wdata(c2_wdata),
      .c2_cmd_in(c2_cmd_in), .c2_rdata(c2_rdata)
   );

   typedef struct packed {
      logic [31:0]  cyc;
      logic [1:0]   valid;
      logic         err;
      logic [L-1:0] rdata;
   } resp_t;

   typedef struct packed {
      logic [31:0]    cyc;
      logic [1:0]     cmd;
      logic [A-1:0]   addr;
      logic [BUS-1:0] wdata;
   } c2_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  oh;
   } gnt_t;

   resp_t resp_q[$];
   c2_t   c2_q[$];
   gnt_t  gnt_q[$];

   int          errors = 0;
   int          checks = 0;
   int          resp_seen = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin
      if (req_ready != 2'b00) begin
         if (gnt_q.size() == 0) chk("req_ready unexpected", {30'b0, req_ready}, '0);
         else                   chk("grant", {cyc, req_ready}, gnt_q.pop_front());
      end
      if (c2_cmd != 2'b00) begin
         if (c2_q.size() == 0) chk("c2 unexpected", {30'b0, c2_cmd}, '0);
         else                  chk("c2 beat", {cyc, c2_cmd, c2_addr, c2_wdata}, c2_q.pop_front());
      end else begin
         chk("c2 idle zero", {c2_addr, c2_wdata}, '0);
      end
      if (resp_valid != 2'b00) begin
         resp_seen++;
         if (resp_q.size() == 0) chk("resp unexpected", {30'b0, resp_valid}, '0);
         else                    chk("resp", {cyc, resp_valid, resp_err, resp_rdata}, resp_q.pop_front());
      end else begin
         chk("resp idle zero", {resp_err, resp_rdata}, '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_read(input int unsigned s, input logic [1:0] oh, input logic [A-1:0] a);
      gnt_q.push_back('{cyc: s, oh: oh});
      c2_q.push_back('{cyc: s + 1, cmd: 2'd2, addr: a, wdata: '0});
   endtask

   task automatic push_write(input int unsigned s, input logic [1:0] oh, input logic [A-1:0] a,
                             input logic [L-1:0] line);
      gnt_q.push_back('{cyc: s, oh: oh});
      for (int k = 0; k < 8; k++)
         c2_q.push_back('{cyc: s + 1 + k, cmd: 2'd3, addr: a, wdata: line[k*BUS +: BUS]});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (resp_q.size() + c2_q.size() + gnt_q.size()) != 0; i++) tick();
      chk("scoreboard drained", {resp_q.size(), c2_q.size(), gnt_q.size()}, '0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      c2_cmd_in = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned s, n;
      logic [L-1:0] wline;

      reset = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      c2_cmd_in = '0; c2_rdata = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("reset outputs", {req_ready, resp_valid, resp_err, resp_rdata, c2_cmd, c2_addr, c2_wdata}, '0);
      tick();
      reset = 1'b1;
      tick();

      // Read, requester 0, memory latency d = 3.
      s = cyc;
      push_read(s, 2'b01, 15'h00A5);
      resp_q.push_back('{cyc: s + 12, valid: 2'b01, err: 1'b0,
                         rdata: 128'h8888_7777_6666_5555_4444_3333_2222_1111});
      req_addr = {15'h0, 15'h00A5}; req_write = 2'b00; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      repeat (3) tick();
      for (int k = 0; k < 8; k++) begin
         c2_cmd_in = 2'd1;
         c2_rdata  = BUS'(16'h1111 * (k + 1));
         tick();
      end
      c2_cmd_in = 2'd0;
      drain();

      // Write, requester 1, RESPONSE five cycles after the last beat.
      s = cyc;
      wline = 128'h0123456789ABCDEF_FEDCBA9876543210;
      push_write(s, 2'b10, 15'h7FFF, wline);
      resp_q.push_back('{cyc: s + 14, valid: 2'b10, err: 1'b0, rdata: '0});
      req_addr = {15'h7FFF, 15'h0}; req_wdata = {wline, 128'h0};
      req_write = 2'b10; req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      repeat (12) tick();
      c2_cmd_in = 2'd1;
      tick();
      c2_cmd_in = 2'd0;
      drain();

      // Tie held from reset, memory always answering: grants 0,1,0,1.
      do_reset();
      s = cyc;
      wline = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      push_read (s,      2'b01, 15'h0011);
      push_write(s + 11, 2'b10, 15'h0022, wline);
      push_read (s + 22, 2'b01, 15'h0011);
      push_write(s + 33, 2'b10, 15'h0022, wline);
      resp_q.push_back('{cyc: s + 10, valid: 2'b01, err: 1'b0, rdata: {8{16'hABCD}}});
      resp_q.push_back('{cyc: s + 21, valid: 2'b10, err: 1'b0, rdata: '0});
      resp_q.push_back('{cyc: s + 32, valid: 2'b01, err: 1'b0, rdata: {8{16'hABCD}}});
      resp_q.push_back('{cyc: s + 43, valid: 2'b10, err: 1'b0, rdata: '0});
      req_addr = {15'h0022, 15'h0011}; req_write = 2'b10; req_wdata = {wline, 128'h0};
      c2_cmd_in = 2'd1; c2_rdata = 16'hABCD;
      req_valid = 2'b11;
      repeat (34) tick();
      req_valid = 2'b00;
      repeat (10) tick();
      c2_cmd_in = 2'd0;
      drain();

      // Gapped read beats, with a stray RESPONSE during RD_CMD.
      s = cyc;
      push_read(s, 2'b01, 15'h1234);
      resp_q.push_back('{cyc: s + 17, valid: 2'b01, err: 1'b0,
                         rdata: 128'hB007_B006_B005_B004_B003_B002_B001_B000});
      req_addr = {15'h0, 15'h1234}; req_write = 2'b00; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      c2_cmd_in = 2'd1; c2_rdata = 16'hDEAD;
      tick();
      for (int k = 0; k < 8; k++) begin
         c2_cmd_in = 2'd1;
         c2_rdata  = BUS'(16'hB000 + k);
         tick();
         c2_cmd_in = 2'd0;
         tick();
      end
      drain();

      // No reply at all.
      s = cyc;
      push_read(s, 2'b01, 15'h0042);
`ifdef MEM_BUS_SCHED_TIMEOUT_EN
      resp_q.push_back('{cyc: s + 18, valid: 2'b01, err: 1'b1, rdata: '0});
      req_addr = {15'h0, 15'h0042}; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      repeat (20) tick();
      drain();
`else
      req_addr = {15'h0, 15'h0042}; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      n = resp_seen;
      repeat (1000) tick();
      chk("no resp while waiting", resp_seen, n);
      do_reset();
      drain();
`endif

      // Reset in RD_WAIT after three beats, then a normal read.
      s = cyc;
      push_read(s, 2'b10, 15'h0555);
      req_addr = {15'h0555, 15'h0}; req_write = 2'b00; req_valid = 2'b10;
      tick();
      req_valid = 2'b00;
      tick();
      for (int k = 0; k < 3; k++) begin
         c2_cmd_in = 2'd1;
         c2_rdata  = BUS'(16'h0101 * (k + 1));
         tick();
      end
      c2_cmd_in = 2'd0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("outputs after mid reset",
          {req_ready, resp_valid, resp_err, resp_rdata, c2_cmd, c2_addr, c2_wdata}, '0);
      tick();
      s = cyc;
      push_read(s, 2'b01, 15'h0777);
      resp_q.push_back('{cyc: s + 10, valid: 2'b01, err: 1'b0,
                         rdata: 128'hC007_C006_C005_C004_C003_C002_C001_C000});
      req_addr = {15'h0, 15'h0777}; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      for (int k = 0; k < 8; k++) begin
         c2_cmd_in = 2'd1;
         c2_rdata  = BUS'(16'hC000 + k);
         tick();
      end
      c2_cmd_in = 2'd0;
      drain();

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
